vote_counter: RTL and testbench

- Ballot-unit front end of the EVM.
- Takes four raw candidate push-buttons plus a presiding-officer ballot key.
- Synchronises and debounces the inputs, enforces one vote per armed ballot, and keeps four saturating per-candidate tallies.
- votecount1..votecount4 feed the downstream winner-decision stage directly, so WIDTH stays at 8 for that stage.

---
 rtl/vote_counter.sv | 190 +++++++++++++++++++
 tb/tb_vote_counter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_counter.sv
// Ballot-unit front end: input synchronisation, button debounce,
// one-vote-per-ballot sequencing and saturating per-candidate tallies.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a ballot key rising edge; clear is honoured here
// ARMED   | one vote allowed; waiting for a debounced button press
// DECIDE  | single cycle: count a single-button press or reject a multi-press
// RELEASE | waiting for all buttons released; ok -> IDLE, reject -> ARMED
module vote_counter #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               ballot,
    input  logic               button1,
    input  logic               button2,
    input  logic               button3,
    input  logic               button4,
    output logic [WIDTH-1:0]   votecount1,
    output logic [WIDTH-1:0]   votecount2,
    output logic [WIDTH-1:0]   votecount3,
    output logic [WIDTH-1:0]   votecount4,
    output logic [WIDTH+1:0]   total_votes,
    output logic               armed,
    output logic               vote_ok,
    output logic               vote_reject
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0]    DEB_MAX   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]    DEB_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] TALLY_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TALLY_ONE = WIDTH'(1);
    localparam logic [WIDTH+1:0] TOTAL_ONE = (WIDTH + 2)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        DECIDE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic             ballot_s1_q, ballot_s1_d;
    logic             ballot_s2_q, ballot_s2_d;
    logic             ballot_prev_q, ballot_prev_d;
    logic [3:0]       btn_s1_q, btn_s1_d;
    logic [3:0]       btn_s2_q, btn_s2_d;
    logic [3:0]       btn_prev_q, btn_prev_d;
    logic [CW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [3:0]       deb_btn_q, deb_btn_d;
    state_t           state_q, state_d;
    logic [3:0]       cap_q, cap_d;
    logic             ok_q, ok_d;
    logic [WIDTH-1:0] tally_q [4];
    logic [WIDTH-1:0] tally_d [4];
    logic [WIDTH+1:0] total_q, total_d;
    logic             vote_ok_q, vote_ok_d;
    logic             vote_reject_q, vote_reject_d;

    logic             ballot_rise;
    logic             btn_changed;
    logic             cap_single;

    // Two-flop synchronisers plus one history stage for edge / change detection.
    always_comb begin
        ballot_s1_d   = ballot;
        ballot_s2_d   = ballot_s1_q;
        ballot_prev_d = ballot_s2_q;
        btn_s1_d      = {button4, button3, button2, button1};
        btn_s2_d      = btn_s1_q;
        btn_prev_d    = btn_s2_q;
    end

    assign ballot_rise = ballot_s2_q & ~ballot_prev_q;
    assign btn_changed = (btn_s2_q != btn_prev_q);

    // Debounce: the synced vector must hold steady until the counter has saturated.
    always_comb begin
        deb_btn_d = deb_btn_q;
        if (btn_changed) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
            deb_cnt_d = deb_cnt_q;
            deb_btn_d = btn_s2_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
    end

    assign cap_single = (cap_q != 4'd0) && ((cap_q & (cap_q - 4'd1)) == 4'd0);

    // Ballot sequencing, tally update and result pulses.
    always_comb begin
        state_d       = state_q;
        cap_d         = cap_q;
        ok_d          = ok_q;
        tally_d       = tally_q;
        total_d       = total_q;
        vote_ok_d     = 1'b0;
        vote_reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    for (int i = 0; i < 4; i++) tally_d[i] = '0;
                    total_d = '0;
                end else if (ballot_rise && (deb_btn_q == 4'd0)) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (deb_btn_q != 4'd0) begin
                    cap_d   = deb_btn_q;
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (cap_single) begin
                    for (int i = 0; i < 4; i++) begin
                        if (cap_q[i] && (tally_q[i] != TALLY_MAX)) begin
                            tally_d[i] = tally_q[i] + TALLY_ONE;
                            total_d    = total_q + TOTAL_ONE;
                        end
                    end
                    vote_ok_d = 1'b1;
                    ok_d      = 1'b1;
                end else begin
                    vote_reject_d = 1'b1;
                    ok_d          = 1'b0;
                end
                state_d = RELEASE;
            end
            RELEASE: begin
                if (deb_btn_q == 4'd0) begin
                    state_d = ok_q ? IDLE : ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers; reset discards any vote in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ballot_s1_q   <= 1'b0;
            ballot_s2_q   <= 1'b0;
            ballot_prev_q <= 1'b0;
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            btn_prev_q    <= '0;
            deb_cnt_q     <= '0;
            deb_btn_q     <= '0;
            state_q       <= IDLE;
            cap_q         <= '0;
            ok_q          <= 1'b0;
            for (int i = 0; i < 4; i++) tally_q[i] <= '0;
            total_q       <= '0;
            vote_ok_q     <= 1'b0;
            vote_reject_q <= 1'b0;
        end else begin
            ballot_s1_q   <= ballot_s1_d;
            ballot_s2_q   <= ballot_s2_d;
            ballot_prev_q <= ballot_prev_d;
            btn_s1_q      <= btn_s1_d;
            btn_s2_q      <= btn_s2_d;
            btn_prev_q    <= btn_prev_d;
            deb_cnt_q     <= deb_cnt_d;
            deb_btn_q     <= deb_btn_d;
            state_q       <= state_d;
            cap_q         <= cap_d;
            ok_q          <= ok_d;
            tally_q       <= tally_d;
            total_q       <= total_d;
            vote_ok_q     <= vote_ok_d;
            vote_reject_q <= vote_reject_d;
        end
    end

    assign votecount1  = tally_q[0];
    assign votecount2  = tally_q[1];
    assign votecount3  = tally_q[2];
    assign votecount4  = tally_q[3];
    assign total_votes = total_q;
    assign armed       = (state_q == ARMED);
    assign vote_ok     = vote_ok_q;
    assign vote_reject = vote_reject_q;

endmodule

// File: tb/tb_vote_counter.sv
// Bench for vote_counter: directed scenarios plus randomized ballot sessions,
// with a scoreboard of expected vote outcomes checked by an independent monitor.
module tb_vote_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       ballot;
    logic       button1, button2, button3, button4;
    logic [7:0] votecount1, votecount2, votecount3, votecount4;
    logic [9:0] total_votes;
    logic       armed, vote_ok, vote_reject;

    vote_counter #(.WIDTH(8), .DEBOUNCE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .ballot      (ballot),
        .button1     (button1),
        .button2     (button2),
        .button3     (button3),
        .button4     (button4),
        .votecount1  (votecount1),
        .votecount2  (votecount2),
        .votecount3  (votecount3),
        .votecount4  (votecount4),
        .total_votes (total_votes),
        .armed       (armed),
        .vote_ok     (vote_ok),
        .vote_reject (vote_reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_ok;
        int t0, t1, t2, t3, tot;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    int   m_tally[4];
    bit   m_armed;
    bit   prev_ok, prev_rej;

    function automatic void check(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int m_sum();
        return m_tally[0] + m_tally[1] + m_tally[2] + m_tally[3];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_tally[i] = 0;
        m_armed = 1'b0;
        sb_q.delete();
    endfunction

    // Monitor: every result pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (vote_ok || vote_reject)) begin
            check("pulse_exclusive", int'(vote_ok && vote_reject), 0);
            check("pulse_width", int'((vote_ok && prev_ok) || (vote_reject && prev_rej)), 0);
            if (sb_q.size() == 0) begin
                total_cnt++;
                bad_cnt++;
                $display("FAIL unexpected_pulse: ok=%0d reject=%0d with no vote pending",
                         vote_ok, vote_reject);
            end else begin
                mon_e = sb_q.pop_front();
                check("event_is_ok", int'(vote_ok), int'(mon_e.is_ok));
                check("ev_votecount1", int'(votecount1), mon_e.t0);
                check("ev_votecount2", int'(votecount2), mon_e.t1);
                check("ev_votecount3", int'(votecount3), mon_e.t2);
                check("ev_votecount4", int'(votecount4), mon_e.t3);
                check("ev_total_votes", int'(total_votes), mon_e.tot);
            end
        end
        prev_ok  = vote_ok;
        prev_rej = vote_reject;
    end

    task automatic set_btn(input logic [3:0] v);
        {button4, button3, button2, button1} = v;
    endtask

    task automatic check_tallies(input string tag);
        check({tag, "_vc1"}, int'(votecount1), m_tally[0]);
        check({tag, "_vc2"}, int'(votecount2), m_tally[1]);
        check({tag, "_vc3"}, int'(votecount3), m_tally[2]);
        check({tag, "_vc4"}, int'(votecount4), m_tally[3]);
        check({tag, "_total"}, int'(total_votes), m_sum());
    endtask

    task automatic do_ballot();
        int k;
        ballot = 1'b1;
        repeat (4) @(negedge clk);
        ballot = 1'b0;
        k = 0;
        while (!armed && k < 12) begin
            @(negedge clk);
            k++;
        end
        check("armed_after_ballot", int'(armed), 1);
        m_armed = 1'b1;
    endtask

    // Reference rule: an armed voter pressing one button casts a vote
    // (saturating); pressing several is rejected and stays armed.
    task automatic model_press(input logic [3:0] v);
        exp_t e;
        if (m_armed) begin
            if ($countones(v) == 1) begin
                for (int i = 0; i < 4; i++)
                    if (v[i] && m_tally[i] < 255) m_tally[i]++;
                e.is_ok = 1'b1;
                m_armed = 1'b0;
            end else begin
                e.is_ok = 1'b0;
            end
            e.t0 = m_tally[0]; e.t1 = m_tally[1];
            e.t2 = m_tally[2]; e.t3 = m_tally[3];
            e.tot = m_sum();
            sb_q.push_back(e);
        end
    endtask

    task automatic press(input logic [3:0] v, input int hold, input bit full_check);
        model_press(v);
        set_btn(v);
        repeat (hold) @(negedge clk);
        set_btn(4'd0);
        repeat (14) @(negedge clk);
        check("armed_after_press", int'(armed), int'(m_armed));
        if (full_check) check_tallies("after_press");
    endtask

    initial begin
        int k;
        logic [3:0] v;
        rst = 1'b1; clear = 1'b0; ballot = 1'b0;
        set_btn(4'd0);
        model_reset();
        prev_ok = 1'b0; prev_rej = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_tallies("reset");
        check("reset_armed", int'(armed), 0);
        check("reset_vote_ok", int'(vote_ok), 0);
        check("reset_vote_reject", int'(vote_reject), 0);

        // single vote on button2
        do_ballot();
        press(4'b0010, 10, 1'b1);

        // multi-press rejected, retry without new ballot
        do_ballot();
        press(4'b0101, 10, 1'b1);
        press(4'b0100, 10, 1'b1);

        // bouncing button4 yields exactly one vote
        do_ballot();
        model_press(4'b1000);
        for (int i = 0; i < 6; i++) begin
            set_btn((i % 2 == 0) ? 4'b1000 : 4'b0000);
            repeat (2) @(negedge clk);
        end
        set_btn(4'b1000);
        repeat (10) @(negedge clk);
        set_btn(4'd0);
        repeat (14) @(negedge clk);
        check_tallies("bounce");
        press(4'b1000, 10, 1'b1);

        // randomized sessions
        for (int s = 0; s < 25; s++) begin
            do_ballot();
            k = 0;
            while (m_armed) begin
                v = (k < 4) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
                press(v, $urandom_range(8, 14), 1'b1);
                k++;
            end
        end

        // clear in IDLE, then build tallies 3,1,0,2 with a clear attempt while ARMED
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) m_tally[i] = 0;
        check_tallies("clear_idle");
        do_ballot();
        clear = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        check("armed_ignores_clear", int'(armed), 1);
        press(4'b0001, 10, 1'b1);
        do_ballot(); press(4'b0001, 10, 1'b0);
        do_ballot(); press(4'b0001, 10, 1'b0);
        do_ballot(); press(4'b0010, 10, 1'b0);
        do_ballot(); press(4'b1000, 10, 1'b0);
        do_ballot(); press(4'b1000, 10, 1'b1);
        check("pre_clear_vc1", int'(votecount1), 3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) m_tally[i] = 0;
        check_tallies("clear_3102");

        // clear together with a ballot edge: cleared, not armed
        do_ballot(); press(4'b0100, 10, 1'b1);
        clear = 1'b1; ballot = 1'b1;
        repeat (6) @(negedge clk);
        clear = 1'b0;
        repeat (6) @(negedge clk);
        check("clear_beats_ballot_armed", int'(armed), 0);
        ballot = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) m_tally[i] = 0;
        check_tallies("clear_with_ballot");

        // saturation of candidate 1
        for (int n = 0; n < 260; n++) begin
            do_ballot();
            press(4'b0001, 8, 1'b0);
        end
        check("sat_vc1", int'(votecount1), 255);
        check("sat_total", int'(total_votes), 255);
        check_tallies("saturate");

        // async reset while in DECIDE with button2 held
        do_ballot();
        set_btn(4'b0010);
        k = 0;
        while (armed && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("reached_decide", int'(armed), 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_tallies("async_reset");
        check("async_reset_armed", int'(armed), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        set_btn(4'd0);
        repeat (14) @(negedge clk);
        check_tallies("post_reset_held");
        check("post_reset_armed", int'(armed), 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
